// File: rtl/wb_interconnect_nslv.sv
// Single-master, N-slave Wishbone classic interconnect with registered decode,
// unmapped-address error, per-transaction watchdog and master-abort handling.
module wb_interconnect_nslv #(
  parameter int NUM_SLAVES  = 4,
  parameter int ADDR_WD     = 32,
  parameter int DATA_WD     = 32,
  parameter int SLV_ADDR_WD = 9,
  parameter int SEL_LSB     = 9,
  parameter int SEL_WD      = 3,
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_WD      = 8
) (
  input  logic                            clk_i,
  input  logic                            rst_n,
  input  logic                            m_wb_cyc_i,
  input  logic                            m_wb_stb_i,
  input  logic                            m_wb_we_i,
  input  logic [ADDR_WD-1:0]              m_wb_adr_i,
  input  logic [DATA_WD-1:0]              m_wb_dat_i,
  input  logic [DATA_WD/8-1:0]            m_wb_sel_i,
  output logic [DATA_WD-1:0]              m_wb_dat_o,
  output logic                            m_wb_ack_o,
  output logic                            m_wb_err_o,
  output logic [NUM_SLAVES-1:0]           s_wb_cyc_o,
  output logic [NUM_SLAVES-1:0]           s_wb_stb_o,
  output logic                            s_wb_we_o,
  output logic [SLV_ADDR_WD-1:0]          s_wb_adr_o,
  output logic [DATA_WD-1:0]              s_wb_dat_o,
  output logic [DATA_WD/8-1:0]            s_wb_sel_o,
  input  logic [NUM_SLAVES*DATA_WD-1:0]   s_wb_dat_i,
  input  logic [NUM_SLAVES-1:0]           s_wb_ack_i
);

  // Handshake: a request is taken when cyc&stb are high in IDLE; the master
  // sees exactly one ack or err cycle per accepted request unless it drops
  // cyc first (abort), in which case it sees neither.
  localparam int SEL_BW = DATA_WD / 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  localparam logic [CNT_WD-1:0] TMO_LIM = CNT_WD'(TIMEOUT_CYC);

  logic [1:0]               state_q, state_d;
  logic [CNT_WD-1:0]        cnt_q, cnt_d;
  logic [NUM_SLAVES-1:0]    cyc_q, cyc_d;
  logic                     we_q, we_d;
  logic [SLV_ADDR_WD-1:0]   adr_q, adr_d;
  logic [DATA_WD-1:0]       wdat_q, wdat_d;
  logic [SEL_BW-1:0]        sel_q, sel_d;
  logic [DATA_WD-1:0]       rdat_q, rdat_d;
  logic                     ack_q, ack_d;
  logic                     err_q, err_d;

  logic [NUM_SLAVES-1:0]    dec;
  logic [DATA_WD-1:0]       ack_dat;
  logic [CNT_WD-1:0]        cnt_inc;
  logic                     ack_hit;
  logic                     tmo_hit;
  logic                     unused_adr;

  // Only the slave-index field and the forwarded low bits are meaningful.
  assign unused_adr = ^m_wb_adr_i;

  // cyc_q doubles as the latched one-hot slave select while in REQ.
  always_comb begin
    dec     = '0;
    ack_dat = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      dec[i]  = (m_wb_adr_i[SEL_LSB +: SEL_WD] == SEL_WD'(i));
      ack_dat = ack_dat | ({DATA_WD{cyc_q[i]}} & s_wb_dat_i[i*DATA_WD +: DATA_WD]);
    end
    ack_hit = |(s_wb_ack_i & cyc_q);
    cnt_inc = cnt_q + CNT_WD'(1);
    tmo_hit = (cnt_inc == TMO_LIM);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    sel_d   = sel_q;
    rdat_d  = rdat_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (m_wb_cyc_i && m_wb_stb_i) begin
          we_d   = m_wb_we_i;
          adr_d  = m_wb_adr_i[SLV_ADDR_WD-1:0];
          wdat_d = m_wb_dat_i;
          sel_d  = m_wb_sel_i;
          cnt_d  = '0;
          if (|dec) begin
            state_d = ST_REQ;
            cyc_d   = dec;
          end else begin
            state_d = ST_ERR;
            err_d   = 1'b1;
            rdat_d  = '0;
          end
        end
      end
      ST_REQ: begin
        // Abort outranks ack, and ack outranks timeout in the same cycle.
        if (!m_wb_cyc_i) begin
          state_d = ST_IDLE;
          cyc_d   = '0;
          cnt_d   = '0;
        end else if (ack_hit) begin
          state_d = ST_RESP;
          cyc_d   = '0;
          cnt_d   = '0;
          ack_d   = 1'b1;
          rdat_d  = we_q ? '0 : ack_dat;
        end else if (tmo_hit) begin
          state_d = ST_ERR;
          cyc_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b1;
          rdat_d  = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      ST_ERR: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cyc_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cyc_q   <= '0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      wdat_q  <= '0;
      sel_q   <= '0;
      rdat_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      sel_q   <= sel_d;
      rdat_q  <= rdat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign m_wb_dat_o = rdat_q;
  assign m_wb_ack_o = ack_q;
  assign m_wb_err_o = err_q;
  assign s_wb_cyc_o = cyc_q;
  assign s_wb_stb_o = cyc_q;
  assign s_wb_we_o  = we_q;
  assign s_wb_adr_o = adr_q;
  assign s_wb_dat_o = wdat_q;
  assign s_wb_sel_o = sel_q;

endmodule

// File: tb/tb_wb_interconnect_nslv.sv
// Scoreboard bench for wb_interconnect_nslv: a master driver, a slave responder
// model and two monitors comparing against a transaction-level reference.
module tb_wb_interconnect_nslv;
  localparam int NS  = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SAW = 9;
  localparam int SL  = 9;
  localparam int SW  = 3;
  localparam int TMO = 255;
  localparam int CW  = 8;
  localparam int BW  = DW / 8;
  localparam int RW  = NS + 1 + SAW + DW + BW;

  logic             clk;
  logic             rst_n;
  logic             m_cyc, m_stb, m_we;
  logic [AW-1:0]    m_adr;
  logic [DW-1:0]    m_dat;
  logic [BW-1:0]    m_sel;
  logic [DW-1:0]    m_wb_dat_o;
  logic             m_wb_ack_o, m_wb_err_o;
  logic [NS-1:0]    s_wb_cyc_o, s_wb_stb_o;
  logic             s_wb_we_o;
  logic [SAW-1:0]   s_wb_adr_o;
  logic [DW-1:0]    s_wb_dat_o;
  logic [BW-1:0]    s_wb_sel_o;
  logic [NS*DW-1:0] s_wb_dat_i;
  logic [NS-1:0]    s_wb_ack_i;

  logic [DW-1:0]    slv_dat[NS];
  int               ack_delay;
  bit               spur_en;

  logic [DW:0]      exp_q[$];
  logic [RW-1:0]    sexp_q[$];

  int checks;
  int errors;

  wb_interconnect_nslv #(
    .NUM_SLAVES(NS), .ADDR_WD(AW), .DATA_WD(DW), .SLV_ADDR_WD(SAW),
    .SEL_LSB(SL), .SEL_WD(SW), .TIMEOUT_CYC(TMO), .CNT_WD(CW)
  ) dut (
    .clk_i(clk), .rst_n(rst_n),
    .m_wb_cyc_i(m_cyc), .m_wb_stb_i(m_stb), .m_wb_we_i(m_we),
    .m_wb_adr_i(m_adr), .m_wb_dat_i(m_dat), .m_wb_sel_i(m_sel),
    .m_wb_dat_o(m_wb_dat_o), .m_wb_ack_o(m_wb_ack_o), .m_wb_err_o(m_wb_err_o),
    .s_wb_cyc_o(s_wb_cyc_o), .s_wb_stb_o(s_wb_stb_o), .s_wb_we_o(s_wb_we_o),
    .s_wb_adr_o(s_wb_adr_o), .s_wb_dat_o(s_wb_dat_o), .s_wb_sel_o(s_wb_sel_o),
    .s_wb_dat_i(s_wb_dat_i), .s_wb_ack_i(s_wb_ack_i)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  for (genvar g = 0; g < NS; g++) begin : g_sdat
    assign s_wb_dat_i[g*DW +: DW] = slv_dat[g];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Slave responder: selected slave acks in its ack_delay-th strobe cycle;
  // unselected slaves may raise stray acks that must be ignored.
  initial begin
    int stb_cnt[NS];
    s_wb_ack_i = '0;
    for (int i = 0; i < NS; i++) stb_cnt[i] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NS; i++) begin
        if (s_wb_stb_o[i]) begin
          stb_cnt[i]++;
          s_wb_ack_i[i] = (stb_cnt[i] == ack_delay);
        end else begin
          stb_cnt[i] = 0;
          s_wb_ack_i[i] = spur_en && ($urandom_range(0, 3) == 0);
        end
      end
    end
  end

  // Master-side monitor
  initial begin
    logic [DW:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && (m_wb_ack_o || m_wb_err_o)) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: ack=%b err=%b with nothing expected", m_wb_ack_o, m_wb_err_o);
        end else begin
          e = exp_q.pop_front();
          check("resp_err", 64'(m_wb_err_o), 64'(e[DW]));
          check("resp_ack", 64'(m_wb_ack_o), 64'(!e[DW]));
          check("resp_dat", 64'(m_wb_dat_o), 64'(e[DW-1:0]));
        end
      end
    end
  end

  // Slave-side monitor
  initial begin
    logic [NS-1:0] prev_stb;
    logic [RW-1:0] cur, act;
    prev_stb = '0;
    cur = '0;
    forever begin
      @(negedge clk);
      act = {s_wb_stb_o, s_wb_we_o, s_wb_adr_o, s_wb_dat_o, s_wb_sel_o};
      check("cyc_onehot0", 64'($onehot0(s_wb_cyc_o)), 64'd1);
      check("cyc_eq_stb", 64'(s_wb_cyc_o), 64'(s_wb_stb_o));
      if (s_wb_stb_o != '0 && prev_stb == '0) begin
        if (sexp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_slv_req: stb=%b", s_wb_stb_o);
        end else begin
          check("slv_req", 64'(act), 64'(sexp_q.pop_front()));
        end
        cur = act;
      end else if (s_wb_stb_o != '0) begin
        check("slv_stable", 64'(act), 64'(cur));
      end
      prev_stb = s_wb_stb_o;
    end
  end

  // Reference: outcome of one request from the address map and slave latency.
  task automatic do_txn(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                        input logic [BW-1:0] sel, input int delay);
    int idx, lat, n;
    bit e, got;
    logic [DW-1:0] d;
    logic [NS-1:0] oh;
    idx = int'(adr[SL +: SW]);
    if (idx >= NS) begin
      e = 1'b1; d = '0; lat = 1;
    end else if (delay > TMO) begin
      e = 1'b1; d = '0; lat = TMO + 1;
    end else begin
      e = 1'b0; d = we ? '0 : slv_dat[idx]; lat = delay + 1;
    end
    exp_q.push_back({e, d});
    if (idx < NS) begin
      oh = NS'(1) << idx;
      sexp_q.push_back({oh, we, adr[SAW-1:0], dat, sel});
    end
    ack_delay = delay;
    m_cyc = 1'b1; m_stb = 1'b1; m_we = we; m_adr = adr; m_dat = dat; m_sel = sel;
    n = 0; got = 1'b0;
    while (!got && n < TMO + 50) begin
      @(posedge clk); #1;
      n++;
      if (m_wb_ack_o || m_wb_err_o) got = 1'b1;
    end
    check("txn_latency", 64'(n), 64'(lat));
    m_cyc = 1'b0; m_stb = 1'b0;
    @(posedge clk); #1;
    check("dat_hold", 64'(m_wb_dat_o), 64'(d));
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mout"}, 64'({m_wb_dat_o, m_wb_ack_o, m_wb_err_o}), 64'd0);
    check({tag, "_sctl"}, 64'({s_wb_cyc_o, s_wb_stb_o, s_wb_we_o}), 64'd0);
    check({tag, "_sbus"}, 64'({s_wb_adr_o, s_wb_dat_o, s_wb_sel_o}), 64'd0);
  endtask

  task automatic do_abort();
    int resp;
    sexp_q.push_back({4'b1000, 1'b0, 9'h010, 32'h0, 4'hf});
    ack_delay = 2;
    m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b0; m_adr = 32'h0000_0610; m_dat = '0; m_sel = 4'hf;
    idle(2);
    m_cyc = 1'b0; m_stb = 1'b0;
    resp = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (m_wb_ack_o || m_wb_err_o) resp++;
    end
    check("abort_no_resp", 64'(resp), 64'd0);
    check("abort_stb", 64'(s_wb_stb_o), 64'd0);
  endtask

  task automatic do_reset_mid();
    int resp;
    sexp_q.push_back({4'b0010, 1'b1, 9'h0a5, 32'hcafe_f00d, 4'b1100});
    ack_delay = 1000;
    m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b1; m_adr = 32'h0000_02a5; m_dat = 32'hcafe_f00d; m_sel = 4'b1100;
    idle(2);
    rst_n = 1'b0;
    m_cyc = 1'b0; m_stb = 1'b0;
    @(posedge clk); #1;
    check_all_zero("rst_mid");
    rst_n = 1'b1;
    resp = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (m_wb_ack_o || m_wb_err_o) resp++;
    end
    check("rst_mid_no_resp", 64'(resp), 64'd0);
  endtask

  initial begin
    logic [AW-1:0] a;
    checks = 0; errors = 0;
    rst_n = 1'b0; m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0;
    m_adr = '0; m_dat = '0; m_sel = '0;
    ack_delay = 1000; spur_en = 1'b0;
    for (int i = 0; i < NS; i++) slv_dat[i] = $urandom;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    idle(1);

    slv_dat[2] = 32'hdead_beef;
    do_txn(1'b0, 32'h0000_0404, 32'h0, 4'hf, 2);
    do_txn(1'b1, 32'h0000_0000, 32'h1234_5678, 4'b0011, 1);
    do_txn(1'b0, 32'h0000_0a00, 32'h0, 4'hf, 1);
    do_txn(1'b0, 32'h0000_0200, 32'h0, 4'hf, 1000);
    do_txn(1'b0, 32'h0000_0200, 32'h0, 4'hf, 1);
    do_txn(1'b0, 32'h0000_0604, 32'h0, 4'hf, TMO);
    do_txn(1'b1, 32'h0000_0e00, 32'h5555_aaaa, 4'hf, 1);
    do_abort();
    do_reset_mid();

    slv_dat[0] = 32'h0000_1111;
    slv_dat[1] = 32'h2222_0000;
    do_txn(1'b0, 32'h0000_0008, 32'h0, 4'hf, 1);
    slv_dat[0] = 32'h3333_4444;
    do_txn(1'b0, 32'h0000_020c, 32'h0, 4'hf, 1);
    do_txn(1'b0, 32'h0000_0010, 32'h0, 4'hf, 1);

    spur_en = 1'b1;
    for (int t = 0; t < 150; t++) begin
      for (int i = 0; i < NS; i++) slv_dat[i] = $urandom;
      a = $urandom;
      a[SL +: SW] = SW'($urandom_range(0, 5));
      do_txn(1'($urandom_range(0, 1)), a, $urandom, BW'($urandom), $urandom_range(1, 6));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    spur_en = 1'b0;
    idle(4);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("sexp_q_drained", 64'(sexp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
